// File: rtl/crc_chk_s.sv
// Serial CRC checker: shifts {data, received crc} MSB-first through a Galois LFSR,
// one bit per clock, and reports pass when the final residue is zero.
module crc_chk_s #(
  parameter int            DW   = 8,
  parameter int            CW   = 8,
  parameter logic [CW-1:0] POLY = CW'(8'h07),
  parameter logic [CW-1:0] INIT = '0
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic [DW-1:0] din,
  input  logic [CW-1:0] crc_in,
  input  logic          req,
  output logic          ready,
  output logic          valid,
  output logic          crc_ok,
  output logic [CW-1:0] residue
);

  localparam int N    = DW + CW;
  localparam int CNTW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   lfsr_reg, lfsr_next;
  logic [N-1:0]    shift_reg, shift_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            ok_reg, ok_next;
  logic [CW-1:0]   residue_reg, residue_next;

  logic            fb;
  logic [CW-1:0]   lfsr_step;

  assign fb = lfsr_reg[CW-1] ^ shift_reg[N-1];

  // One Galois step: shift left, fold the polynomial in wherever the feedback bit is set.
  generate
    for (genvar gi = 0; gi < CW; gi++) begin : g_step
      if (gi == 0) begin : g_lsb
        assign lfsr_step[gi] = fb & POLY[gi];
      end else begin : g_upper
        assign lfsr_step[gi] = lfsr_reg[gi-1] ^ (fb & POLY[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg   <= IDLE;
      lfsr_reg    <= '0;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      ok_reg      <= 1'b0;
      residue_reg <= '0;
    end else begin
      state_reg   <= state_next;
      lfsr_reg    <= lfsr_next;
      shift_reg   <= shift_next;
      cnt_reg     <= cnt_next;
      ok_reg      <= ok_next;
      residue_reg <= residue_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    lfsr_next    = lfsr_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    ok_next      = ok_reg;
    residue_next = residue_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = CALC;
          lfsr_next  = INIT;
          shift_next = {din, crc_in};
          cnt_next   = CNTW'(N);
        end
      end
      CALC: begin
        lfsr_next  = lfsr_step;
        shift_next = shift_reg << 1;
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNTW'(1);
        end
        // The last shift lands in the same edge that enters DONE, so capture its result now.
        if (cnt_reg <= CNTW'(1)) begin
          state_next   = DONE;
          ok_next      = (lfsr_step == '0);
          residue_next = lfsr_step;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ready   = (state_reg == IDLE);
  assign valid   = (state_reg == DONE);
  assign crc_ok  = ok_reg;
  assign residue = residue_reg;

endmodule

// File: tb/tb_crc_chk_s.sv
// Directed bench for crc_chk_s: CRC-8 vectors on the default build plus a
// DW=16/INIT=FF build checked against a bit-serial generator model.
module tb_crc_chk_s;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic [7:0]  din_a, crc_a, res_a;
  logic        req_a, ready_a, valid_a, ok_a;
  logic [15:0] din_b;
  logic [7:0]  crc_b, res_b;
  logic        req_b, ready_b, valid_b, ok_b;

  int n_tests = 0;
  int n_fail  = 0;

  crc_chk_s dut_a (
    .clk(clk), .rst_b(rst_b), .din(din_a), .crc_in(crc_a), .req(req_a),
    .ready(ready_a), .valid(valid_a), .crc_ok(ok_a), .residue(res_a)
  );

  crc_chk_s #(.DW(16), .CW(8), .POLY(8'h07), .INIT(8'hFF)) dut_b (
    .clk(clk), .rst_b(rst_b), .din(din_b), .crc_in(crc_b), .req(req_b),
    .ready(ready_b), .valid(valid_b), .crc_ok(ok_b), .residue(res_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference generator: serial CRC of a 16-bit word, same polynomial and INIT=FF.
  function automatic logic [7:0] gen16(input logic [15:0] m);
    logic [7:0] l;
    logic       f;
    l = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      f = l[7] ^ m[i];
      l = {l[6:0], 1'b0} ^ (f ? 8'h07 : 8'h00);
    end
    return l;
  endfunction

  // Submit one word to dut_a; optionally raise a stray req at busy cycle inj.
  task automatic run_a(input logic [7:0] d, input logic [7:0] c, input int inj,
                       output int lat, output logic ok, output logic [7:0] res);
    @(negedge clk);
    check("ready_before", 32'(ready_a), 32'd1);
    din_a = d; crc_a = c; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    lat = 1;
    while (!valid_a && lat < 40) begin
      @(negedge clk);
      lat++;
      req_a = 1'b0;
      if (lat == inj) begin
        check("busy_ready", 32'(ready_a), 32'd0);
        din_a = 8'hFF; crc_a = 8'h00; req_a = 1'b1;
      end
    end
    check("valid_seen", 32'(valid_a), 32'd1);
    ok = ok_a; res = res_a;
    $display("[TB] a din=%h crc=%h lat=%0d ok=%0d res=%h", d, c, lat, ok, res);
    @(negedge clk);
    check("valid_pulse", 32'(valid_a), 32'd0);
    check("ready_back", 32'(ready_a), 32'd1);
  endtask

  task automatic run_b(input logic [15:0] d, input logic [7:0] c,
                       output int lat, output logic ok);
    @(negedge clk);
    din_b = d; crc_b = c; req_b = 1'b1;
    @(negedge clk);
    req_b = 1'b0;
    lat = 1;
    while (!valid_b && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    ok = ok_b;
  endtask

  initial begin
    int         lat, t1, t2, vcount, flip, pos;
    logic       ok;
    logic [7:0] res, c;
    logic [15:0] m;
    logic [23:0] word;

    rst_b = 1'b0; req_a = 1'b0; din_a = '0; crc_a = '0;
    req_b = 1'b0; din_b = '0; crc_b = '0;
    #12;
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_ok", 32'(ok_a), 32'd0);
    check("rst_res", 32'(res_a), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // 1: good word
    run_a(8'h31, 8'h97, 0, lat, ok, res);
    check("t1_lat", 32'(lat), 32'd17);
    check("t1_ok", 32'(ok), 32'd1);
    check("t1_res", 32'(res), 32'h00);
    repeat (3) @(negedge clk);
    check("t1_hold_ok", 32'(ok_a), 32'd1);

    // 3: stray req mid-CALC must be ignored
    run_a(8'h31, 8'h97, 5, lat, ok, res);
    check("t3_lat", 32'(lat), 32'd17);
    check("t3_ok", 32'(ok), 32'd1);
    check("t3_res", 32'(res), 32'h00);
    repeat (20) @(negedge clk);
    check("t3_no_extra", 32'(ready_a), 32'd1);

    // 4: req held high across two words
    @(negedge clk);
    din_a = 8'h31; crc_a = 8'h97; req_a = 1'b1;
    t1 = 0; t2 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin din_a = 8'h00; crc_a = 8'h00; end
      if (k == 18) check("t4_ready18", 32'(ready_a), 32'd1);
      if (k == 19) req_a = 1'b0;
      if (valid_a) begin
        if (t1 == 0) begin
          t1 = k;
          check("t4_ok1", 32'(ok_a), 32'd1);
        end else if (t2 == 0) begin
          t2 = k;
          check("t4_ok2", 32'(ok_a), 32'd1);
        end
      end
    end
    $display("[TB] b2b first=%0d second=%0d", t1, t2);
    check("t4_first", 32'(t1), 32'd17);
    check("t4_gap", 32'(t2 - t1), 32'd18);

    // 2: single-bit error in the CRC byte
    run_a(8'h31, 8'h96, 0, lat, ok, res);
    check("t2_ok", 32'(ok), 32'd0);
    check("t2_res", 32'(res), 32'h07);

    // 5: reset in the middle of CALC
    @(negedge clk);
    din_a = 8'h31; crc_a = 8'h97; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    repeat (4) @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("t5_ready", 32'(ready_a), 32'd1);
    check("t5_valid", 32'(valid_a), 32'd0);
    check("t5_ok", 32'(ok_a), 32'd0);
    check("t5_res", 32'(res_a), 32'h00);
    @(negedge clk);
    rst_b = 1'b1;
    vcount = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (valid_a) vcount++;
    end
    check("t5_no_valid", 32'(vcount), 32'd0);
    run_a(8'h31, 8'h97, 0, lat, ok, res);
    check("t5_after_lat", 32'(lat), 32'd17);
    check("t5_after_ok", 32'(ok), 32'd1);

    // 6: loopback against the generator model, random single-bit flips
    for (int w = 0; w < 1000; w++) begin
      m = 16'($urandom);
      c = gen16(m);
      word = {m, c};
      flip = int'($urandom_range(0, 1));
      if (flip != 0) begin
        pos = int'($urandom_range(0, 23));
        word[pos] = ~word[pos];
      end
      run_b(word[23:8], word[7:0], lat, ok);
      $display("[TB] b w=%0d word=%h flip=%0d lat=%0d ok=%0d", w, word, flip, lat, ok);
      check("t6_lat", 32'(lat), 32'd25);
      check("t6_ok", 32'(ok), 32'(flip == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
